// File: rtl/mem_responder_if.sv
// Handshake bus between the CPU's MAR/MDR datapath and the memory responder.
// The initiator drives MOV and the request fields; the responder answers on MOC and DataOut.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);

  logic              MOV;
  logic              RW;
  logic [1:0]        DataType;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;

  modport master (
    output MOV, RW, DataType, Address, DataIn,
    input  DataOut, MOC
  );

  modport slave (
    input  MOV, RW, DataType, Address, DataIn,
    output DataOut, MOC
  );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: captures a MOV request, waits WAIT_CYCLES, performs a
// big-endian byte/halfword/word access on an internal RAM and completes with a
// four-phase MOV/MOC handshake. RAM contents survive reset.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_out_q, data_out_d;

  logic [7:0]        mem [DEPTH];

  logic              moc;
  logic              do_access;
  logic [ADDR_W-1:0] byte_addr [4];
  logic [7:0]        wbyte [4];
  logic [3:0]        we;
  logic [31:0]       rd_data;

  // Next-state logic: capture the request in IDLE, count wait states in BUSY, wait for MOV low in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          type_d  = bus.DataType;
          addr_d  = bus.Address;
          wdata_d = bus.DataIn;
          cnt_d   = WAIT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.MOV) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: MOC follows DONE; byte lanes, write enables and read data for the completing access.
  always_comb begin
    moc       = (state_q == DONE);
    do_access = (state_q == BUSY) && (cnt_q == 4'd0);
    we        = 4'b0000;
    rd_data   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = addr_q + ADDR_W'(i);
      wbyte[i]     = 8'h0;
    end
    case (type_q)
      2'b00: begin
        wbyte[0] = wdata_q[7:0];
        we       = 4'b0001;
        rd_data  = {24'h0, mem[byte_addr[0]]};
      end
      2'b01: begin
        wbyte[0] = wdata_q[15:8];
        wbyte[1] = wdata_q[7:0];
        we       = 4'b0011;
        rd_data  = {16'h0, mem[byte_addr[0]], mem[byte_addr[1]]};
      end
      2'b10: begin
        wbyte[0] = wdata_q[31:24];
        wbyte[1] = wdata_q[23:16];
        wbyte[2] = wdata_q[15:8];
        wbyte[3] = wdata_q[7:0];
        we       = 4'b1111;
        rd_data  = {mem[byte_addr[0]], mem[byte_addr[1]],
                    mem[byte_addr[2]], mem[byte_addr[3]]};
      end
      default: begin
        we      = 4'b0000;
        rd_data = 32'h0;
      end
    endcase
    if (!(do_access && !rw_q)) begin
      we = 4'b0000;
    end
    data_out_d = (do_access && rw_q) ? rd_data : data_out_q;
  end

  // State register with synchronous reset; RAM is deliberately not part of this.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      type_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
    end
  end

  // RAM write port: all enabled bytes commit on the completion edge; a reset on that edge aborts the write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[byte_addr[i]] <= wbyte[i];
        end
      end
    end
  end

  assign bus.MOC     = moc;
  assign bus.DataOut = data_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver pushes the expected DataOut of
// every transaction, and a monitor checks it when MOC rises. The driver also
// checks handshake latency cycle by cycle.
module tb_mem_responder;

  localparam int         WAIT = 2;
  localparam logic       RD   = 1'b1;
  localparam logic       WR   = 1'b0;
  localparam logic [1:0] TB_B = 2'b00;
  localparam logic [1:0] TB_H = 2'b01;
  localparam logic [1:0] TB_W = 2'b10;
  localparam logic [1:0] TB_R = 2'b11;

  logic CLK = 1'b0;
  logic RST;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  logic        moc_prev = 1'b0;

  mem_responder_if #(.ADDR_W(8)) bus ();

  mem_responder #(
    .ADDR_W      (8),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: on each MOC rising edge, pop the oldest expected DataOut and compare.
  always @(negedge CLK) begin
    if (bus.MOC === 1'b1 && moc_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_moc: got MOC=1, expected no completion");
      end else begin
        checkOutput("data_out", bus.DataOut, exp_q.pop_front());
      end
    end
    moc_prev = bus.MOC;
  end

  // One full handshake; request fields are scrambled right after capture to show they are ignored.
  task automatic applyStimulus(input string name, input logic rw, input logic [1:0] dt,
                               input logic [7:0] a, input logic [31:0] din,
                               input logic [31:0] exp_out, input int hold);
    @(negedge CLK);
    bus.MOV      = 1'b1;
    bus.RW       = rw;
    bus.DataType = dt;
    bus.Address  = a;
    bus.DataIn   = din;
    exp_q.push_back(exp_out);
    @(posedge CLK);
    #1;
    checkOutput({name, "_moc_capture"}, 32'(bus.MOC), 32'h0);
    bus.RW       = ~rw;
    bus.DataType = ~dt;
    bus.Address  = ~a;
    bus.DataIn   = ~din;
    repeat (WAIT) begin
      @(posedge CLK);
      #1;
      checkOutput({name, "_moc_wait"}, 32'(bus.MOC), 32'h0);
    end
    @(posedge CLK);
    #1;
    checkOutput({name, "_moc_done"}, 32'(bus.MOC), 32'h1);
    repeat (hold) begin
      @(posedge CLK);
      #1;
      checkOutput({name, "_moc_hold"}, 32'(bus.MOC), 32'h1);
    end
    @(negedge CLK);
    bus.MOV = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput({name, "_moc_release"}, 32'(bus.MOC), 32'h0);
  endtask

  // Start a word write and hit it with reset while it is still waiting.
  task automatic abortWithReset();
    @(negedge CLK);
    bus.MOV      = 1'b1;
    bus.RW       = WR;
    bus.DataType = TB_W;
    bus.Address  = 8'h40;
    bus.DataIn   = 32'h55555555;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("abort_moc", 32'(bus.MOC), 32'h0);
    checkOutput("abort_data_out", bus.DataOut, 32'h0);
    @(negedge CLK);
    RST     = 1'b0;
    bus.MOV = 1'b0;
    repeat (WAIT + 2) begin
      @(posedge CLK);
      #1;
      checkOutput("abort_moc_stays_low", 32'(bus.MOC), 32'h0);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expected DataOut values.
  initial begin
    RST          = 1'b1;
    bus.MOV      = 1'b0;
    bus.RW       = 1'b0;
    bus.DataType = 2'b00;
    bus.Address  = 8'h00;
    bus.DataIn   = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_moc", 32'(bus.MOC), 32'h0);
    checkOutput("reset_data_out", bus.DataOut, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    applyStimulus("wr_w10",  WR, TB_W, 8'h10, 32'hDEADBEEF, 32'h00000000, 5);
    applyStimulus("rd_w10",  RD, TB_W, 8'h10, 32'h0,        32'hDEADBEEF, 0);
    applyStimulus("rd_b10",  RD, TB_B, 8'h10, 32'h0,        32'h000000DE, 0);
    applyStimulus("rd_b11",  RD, TB_B, 8'h11, 32'h0,        32'h000000AD, 0);
    applyStimulus("rd_b12",  RD, TB_B, 8'h12, 32'h0,        32'h000000BE, 0);
    applyStimulus("rd_b13",  RD, TB_B, 8'h13, 32'h0,        32'h000000EF, 0);
    applyStimulus("rd_h11",  RD, TB_H, 8'h11, 32'h0,        32'h0000ADBE, 0);

    applyStimulus("wr_h20",  WR, TB_H, 8'h20, 32'h00001234, 32'h0000ADBE, 0);
    applyStimulus("wr_b21",  WR, TB_B, 8'h21, 32'hABCDEFFF, 32'h0000ADBE, 0);
    applyStimulus("rd_h20",  RD, TB_H, 8'h20, 32'h0,        32'h000012FF, 0);

    applyStimulus("wr_wFE",  WR, TB_W, 8'hFE, 32'hA1B2C3D4, 32'h000012FF, 0);
    applyStimulus("rd_bFE",  RD, TB_B, 8'hFE, 32'h0,        32'h000000A1, 0);
    applyStimulus("rd_bFF",  RD, TB_B, 8'hFF, 32'h0,        32'h000000B2, 0);
    applyStimulus("rd_b00",  RD, TB_B, 8'h00, 32'h0,        32'h000000C3, 0);
    applyStimulus("rd_b01",  RD, TB_B, 8'h01, 32'h0,        32'h000000D4, 0);
    applyStimulus("rd_wFE",  RD, TB_W, 8'hFE, 32'h0,        32'hA1B2C3D4, 0);

    applyStimulus("wr_w40",  WR, TB_W, 8'h40, 32'h00000000, 32'hA1B2C3D4, 0);
    abortWithReset();
    applyStimulus("rd_w40",  RD, TB_W, 8'h40, 32'h0,        32'h00000000, 0);
    applyStimulus("rd_w10b", RD, TB_W, 8'h10, 32'h0,        32'hDEADBEEF, 0);

    applyStimulus("wr_r10",  WR, TB_R, 8'h10, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
    applyStimulus("rd_r10",  RD, TB_R, 8'h10, 32'h0,        32'h00000000, 0);
    applyStimulus("rd_w10c", RD, TB_W, 8'h10, 32'h0,        32'hDEADBEEF, 0);

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
